udma_i2c_pad_filter: RTL
========================

Name: udma_i2c_pad_filter

Overview:
Input-conditioning stage that sits directly downstream of the I2C pads and upstream of the udma_i2c_top core's scl_i/sda_i inputs. It synchronises the raw SCL/SDA pad inputs into periph_clk_i and applies a programmable digital glitch filter. It produces clean SCL/SDA levels, single-cycle SCL edge pulses, and START/STOP condition pulses. It also tracks bus-busy state so the core can detect a multi-master bus.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per line (legal range 2..4)
CNT_W, 4, width of filter-length config and stability counter
TIMEOUT_W, 16, width of SCL-low timeout counter (used only with the optional feature)

Ports:
periph_clk_i  in  1  peripheral clock; all logic on this domain
rstn_i  in  1  asynchronous active-low reset
scl_pad_i  in  1  raw SCL from pad (pad_to_i2c.scl_i)
sda_pad_i  in  1  raw SDA from pad (pad_to_i2c.sda_i)
cfg_filt_len_i  in  CNT_W  stable cycles required before a level change is accepted; 0 = no filtering
cfg_timeout_i  in  TIMEOUT_W  SCL-low timeout threshold in cycles; 0 = disabled
scl_o  out  1  filtered SCL level, to core scl_i
sda_o  out  1  filtered SDA level, to core sda_i
scl_rise_o  out  1  1-cycle pulse on filtered SCL 0->1
scl_fall_o  out  1  1-cycle pulse on filtered SCL 1->0
start_o  out  1  1-cycle pulse on START or repeated START
stop_o  out  1  1-cycle pulse on STOP
bus_busy_o  out  1  high between START and STOP
timeout_o  out  1  1-cycle pulse when SCL-low timeout expires

Behaviour:
- Reset values. While rstn_i is low, all synchroniser flops, scl_o and sda_o are 1, because the idle bus is high. Both counters are 0. All pulses and bus_busy_o are 0. Reset asserted mid-transfer returns the block to idle immediately, with no START/STOP pulse.
- Synchroniser. Each line passes through a SYNC_STAGES flop chain. The last stage is called s_scl/s_sda.
- Filter, per line:
  - A stability counter clears whenever s_x == x_o.
  - When s_x != x_o, the counter increments each cycle.
  - x_o takes the value of s_x in the cycle the counter reaches L = max(cfg_filt_len_i, 1); the counter then clears.
  - A glitch shorter than L cycles never propagates.
  - Latency from a stable pad change to x_o is SYNC_STAGES + L cycles.
- Counter saturates; no wrap-around is possible because it clears at L.
- cfg_filt_len_i may change at any time. The new value applies from the next comparison. If the counter is already >= the new L, x_o updates in the next cycle.
- Edge and condition detection are registered, so the pulses fire 1 cycle after the filtered change:
  - scl_rise_o / scl_fall_o follow transitions of scl_o.
  - start_o requires sda_o 1->0 while scl_o is 1 in both the previous and current cycle.
  - stop_o requires sda_o 0->1 under the same SCL condition.
  - If scl_o and sda_o change in the same cycle, neither START nor STOP is flagged.
- Bus-busy state machine:
  - States: IDLE (bus_busy_o = 0) and BUSY (bus_busy_o = 1).
  - IDLE -> BUSY on a START. BUSY -> IDLE on a STOP.
  - START while BUSY is a repeated START: start_o pulses and the state stays BUSY.
  - STOP while IDLE: stop_o pulses and the state stays IDLE.
  - bus_busy_o changes in the same cycle as the start_o/stop_o pulse.

Optional Feature:
- Macro: I2C_PAD_FILTER_TIMEOUT_EN.
- With the macro defined:
  - A TIMEOUT_W-bit counter increments while scl_o == 0 and bus_busy_o == 1, and clears otherwise.
  - When the count equals a non-zero cfg_timeout_i, timeout_o pulses for 1 cycle, the state machine is forced to IDLE, and the counter clears.
  - The counter saturates and does not fire again until SCL goes high.
- Without the macro: no counter is instantiated, timeout_o is tied to 0, and cfg_timeout_i is ignored.

Test Plan:
1. Glitch rejection: SYNC_STAGES=2, cfg_filt_len_i=4. Drive a 3-cycle low glitch on sda_pad_i -> sda_o stays 1 and no pulses fire. Then drive a 4-cycle low level -> sda_o falls exactly 6 cycles after the pad edge.
2. START/STOP: cfg_filt_len_i=2, SCL held high. SDA 1->0 -> one start_o pulse and bus_busy_o=1. SDA 0->1 -> one stop_o pulse and bus_busy_o=0.
3. Repeated START: from BUSY, toggle SCL low, raise SDA, raise SCL, drop SDA -> second start_o pulse, bus_busy_o stays 1, no stop_o.
4. Simultaneous change: SCL and SDA fall in the same pad cycle with equal filter length -> scl_fall_o pulses once and start_o stays 0.
5. Reset mid-transfer: assert rstn_i low while in BUSY with scl_o=0 -> scl_o=sda_o=1 and bus_busy_o=0 immediately. No pulses after release.
6. Timeout (macro defined): cfg_timeout_i=100, BUSY, SCL held low for 150 cycles -> timeout_o pulses exactly once, 100 cycles after scl_o falls, and bus_busy_o becomes 0. Without the macro, timeout_o stays 0.

Source files
------------

// File: rtl/udma_i2c_pad_filter_if.sv
// Pad-side inputs, filter config and conditioned outputs of udma_i2c_pad_filter.
// master = pad/config driver and consumer of outputs, slave = the filter.
interface udma_i2c_pad_filter_if #(
  parameter int CNT_W     = 4,
  parameter int TIMEOUT_W = 16
);
  logic                 scl_pad_i;
  logic                 sda_pad_i;
  logic [CNT_W-1:0]     cfg_filt_len_i;
  logic [TIMEOUT_W-1:0] cfg_timeout_i;
  logic                 scl_o;
  logic                 sda_o;
  logic                 scl_rise_o;
  logic                 scl_fall_o;
  logic                 start_o;
  logic                 stop_o;
  logic                 bus_busy_o;
  logic                 timeout_o;

  modport master (
    output scl_pad_i, sda_pad_i, cfg_filt_len_i, cfg_timeout_i,
    input  scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, bus_busy_o, timeout_o
  );

  modport slave (
    input  scl_pad_i, sda_pad_i, cfg_filt_len_i, cfg_timeout_i,
    output scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, bus_busy_o, timeout_o
  );
endinterface

// File: rtl/udma_i2c_pad_filter.sv
// I2C pad conditioning: synchroniser + glitch filter per line, edge/START/STOP detect, bus-busy FSM.
// Optional SCL-low timeout enabled by defining I2C_PAD_FILTER_TIMEOUT_EN.

module udma_i2c_pad_filter_line #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             pad_i,
  input  logic [CNT_W-1:0] filt_len_i,
  output logic             lvl_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W:0]         cnt_inc;
  logic [CNT_W:0]         len_eff;
  logic                   s_x;

  assign s_x     = sync_q[SYNC_STAGES-1];
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
  // A length of 0 still needs one comparison cycle, so it behaves as 1.
  assign len_eff = (filt_len_i == '0) ? (CNT_W+1)'(1) : {1'b0, filt_len_i};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '1;
      cnt_q  <= '0;
      lvl_o  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
      if (s_x == lvl_o) begin
        cnt_q <= '0;
      end else if (cnt_inc >= len_eff) begin
        lvl_o <= s_x;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_inc[CNT_W-1:0];
      end
    end
  end
endmodule

module udma_i2c_pad_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int TIMEOUT_W   = 16
) (
  input logic                  periph_clk_i,
  input logic                  rstn_i,
  udma_i2c_pad_filter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  logic [1:0] pad_vec;
  logic [1:0] lvl_vec;
  logic       scl, sda;
  logic       scl_q, sda_q;
  logic       start_det, stop_det, to_hit;
  logic       rise_q, fall_q, start_q, stop_q, busy_q, to_q;
  state_t     state_q;

  assign pad_vec = {bus.sda_pad_i, bus.scl_pad_i};

  for (genvar i = 0; i < 2; i++) begin : g_line
    udma_i2c_pad_filter_line #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_line (
      .clk_i     (periph_clk_i),
      .rstn_i    (rstn_i),
      .pad_i     (pad_vec[i]),
      .filt_len_i(bus.cfg_filt_len_i),
      .lvl_o     (lvl_vec[i])
    );
  end

  assign scl = lvl_vec[0];
  assign sda = lvl_vec[1];

  // SCL must be high on both sides of the SDA edge, so a joint SCL/SDA change never qualifies.
  assign start_det = scl & scl_q & sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q & sda;

`ifdef I2C_PAD_FILTER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tcnt_q;
  logic [TIMEOUT_W-1:0] tcnt_inc;

  assign tcnt_inc = tcnt_q + TIMEOUT_W'(1);
  assign to_hit   = (state_q == BUSY) && !scl && (bus.cfg_timeout_i != '0) &&
                    (tcnt_q != '1) && (tcnt_inc == bus.cfg_timeout_i);

  always_ff @(posedge periph_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tcnt_q <= '0;
    end else if ((state_q != BUSY) || scl || to_hit) begin
      tcnt_q <= '0;
    end else if (tcnt_q != '1) begin
      tcnt_q <= tcnt_inc;
    end
  end
`else
  logic [TIMEOUT_W-1:0] unused_cfg_timeout;
  assign unused_cfg_timeout = bus.cfg_timeout_i;
  assign to_hit             = 1'b0;
`endif

  always_ff @(posedge periph_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      scl_q   <= scl;
      sda_q   <= sda;
      rise_q  <= scl & ~scl_q;
      fall_q  <= ~scl & scl_q;
      start_q <= start_det;
      stop_q  <= stop_det;
      to_q    <= to_hit;
      case (state_q)
        IDLE: if (start_det) begin
          state_q <= BUSY;
          busy_q  <= 1'b1;
        end
        BUSY: if (to_hit || stop_det) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.scl_o      = scl;
  assign bus.sda_o      = sda;
  assign bus.scl_rise_o = rise_q;
  assign bus.scl_fall_o = fall_q;
  assign bus.start_o    = start_q;
  assign bus.stop_o     = stop_q;
  assign bus.bus_busy_o = busy_q;
  assign bus.timeout_o  = to_q;
endmodule
